jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller for the JTAG core.
- Sequences the data-register block: 16-state TAP FSM driven by TMS, 4-bit instruction register, instruction decode to the per-instruction SELECT lines, 1-bit bypass register, and the TDO output mux across IR, bypass, BSR, ID and USER scan chains.
- Sits between the chip JTAG pins and the DR block; the DR block derives its own CLOCKDR from the CAPTUREDR/SHIFTDR strobes issued here.

Parameters:
- IR_WIDTH, 4, instruction register width; encodings below assume 4.
- IR_CAPTURE, 4'b0101, value loaded into the IR shift stage in Capture-IR; LSBs must be 2'b01.
- IR_RESET, 4'b0101, instruction loaded at reset and in Test-Logic-Reset (IDCODE).

Ports:
- TCK  input  1  test clock; only clock.
- TRST  input  1  asynchronous active-high reset.
- TMS  input  1  mode select, sampled on posedge TCK.
- TDI  input  1  serial data in.
- TDO  output  1  serial data out, changes on negedge TCK.
- TDO_EN  output  1  pad output enable; high only while shifting.
- ENABLE  output  1  high in any DR state, Capture-DR through Update-DR.
- CAPTUREDR, SHIFTDR, UPDATEDR  output  1 each  state decodes.
- BSR_TDO, ID_REG_TDO, USER_REG_TDO  input  1 each  chain outputs from the DR block.
- BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT, CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT  output  1 each  one-hot instruction decode.

Behaviour:
- Reset: one clock, TCK. Reset is asynchronous and active-high: TRST=1 immediately forces the following, regardless of TCK:
  - state = Test-Logic-Reset (TLR);
  - IR = IR_RESET;
  - IR shift stage = 0, bypass = 0;
  - TDO = 0, TDO_EN = 0;
  - all strobes low;
  - IDCODE_SELECT = 1, all other SELECTs = 0.
- FSM transitions on posedge TCK, per the standard 1149.1 table. States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
  - TMS=1 for 5 consecutive posedges reaches TLR from any state.
  - In TLR: IR is reloaded with IR_RESET every cycle.
- State decodes are Moore outputs of the state register, with no added latency:
  - CAPTUREDR = CapDR; SHIFTDR = ShDR; UPDATEDR = UpdDR.
  - The DR block therefore shifts at every posedge TCK spent in ShDR.
- IR shift stage (posedge TCK):
  - CapIR: load IR_CAPTURE.
  - ShIR: load {TDI, sr[IR_WIDTH-1:1]}, LSB out first.
  - All other states: hold.
- IR update: on negedge TCK while in UpdIR, IR <= shift stage. SELECT outputs change only at that negedge or at reset/TLR.
- Decode. Any other code selects BYPASS, so exactly one SELECT is always high.
  - 0x0 EXTEST, 0x1 SAMPLE, 0x2 INTEST, 0x3 RUNBIST, 0x4 CLAMP, 0x5 IDCODE, 0x6 USERCODE, 0x7 HIGHZ, 0xF BYPASS.
- Bypass register (posedge TCK): CapDR loads 0; ShDR loads TDI. It is used when BYPASS, CLAMP or HIGHZ is selected.
- TDO mux, registered on negedge TCK:
  - ShIR: IR shift stage [0].
  - ShDR: by instruction: IDCODE → ID_REG_TDO; USERCODE → USER_REG_TDO; EXTEST/SAMPLE/INTEST/RUNBIST → BSR_TDO; otherwise → bypass.
  - Other states: hold previous TDO.
  - TDO_EN <= (state==ShIR || state==ShDR), on the same negedge.
- Reset mid-shift: IR is not updated, the partially shifted value is discarded, and IDCODE is active after TRST falls.

Optional Feature:
- Macro TAP_STATE_PORT_EN.
- Defined: adds output TAP_STATE [3:0], the raw state register. Encoding follows the 1149.1 Table-6-3 style: TLR=4'hF, RTI=4'hC, ShDR=4'h2, ShIR=4'hA, UpdDR=4'h5, UpdIR=4'hD, etc. Reset value 4'hF.
- Undefined: port absent, and the state encoding is left to synthesis.

Test Plan:
- Pulse TRST=1 mid-ShDR, release → all SELECTs 0 except IDCODE_SELECT=1; TDO=0; TDO_EN=0; state TLR.
- From RTI, TMS=1,1,1,1,1 → TLR after 5th posedge; IR==4'b0101 and IDCODE_SELECT=1.
- Enter ShIR, shift 4 bits with TDI=1,1,1,1 → TDO sequence 1,0,1,0 (capture 0101, LSB first); after UpdIR negedge, BYPASS_SELECT=1.
- BYPASS selected, ShDR, TDI=1,0,1,1 → TDO=0,1,0,1 (one-cycle bypass delay, first bit from captured 0).
- Load IR=0x9 (undefined) → BYPASS_SELECT=1, all others 0; load IR=0x6 → USERCODE_SELECT=1, and TDO in ShDR follows USER_REG_TDO.
- EXTEST loaded, CapDR→ShDR for 8 cycles → CAPTUREDR high exactly 1 TCK, SHIFTDR high 8 TCKs, UPDATEDR high 1 TCK, ENABLE high across all, TDO_EN high only during ShDR.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller with the 16-state FSM, instruction register, decode, bypass and TDO mux.
// Optional macro TAP_STATE_PORT_EN exposes the raw state register on TAP_STATE using the standard 4-bit encoding.
module jtag_tap_ctrl #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101,
  parameter logic [IR_WIDTH-1:0] IR_RESET   = 4'b0101
) (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  output logic       TDO,
  output logic       TDO_EN,
  output logic       ENABLE,
  output logic       CAPTUREDR,
  output logic       SHIFTDR,
  output logic       UPDATEDR,
  input  logic       BSR_TDO,
  input  logic       ID_REG_TDO,
  input  logic       USER_REG_TDO,
  output logic       BYPASS_SELECT,
  output logic       SAMPLE_SELECT,
  output logic       EXTEST_SELECT,
  output logic       INTEST_SELECT,
  output logic       RUNBIST_SELECT,
  output logic       CLAMP_SELECT,
  output logic       IDCODE_SELECT,
  output logic       USERCODE_SELECT,
  output logic       HIGHZ_SELECT
`ifdef TAP_STATE_PORT_EN
  ,
  output logic [3:0] TAP_STATE
`endif
);

`ifdef TAP_STATE_PORT_EN
  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
    SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
    UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
    EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } state_t;
`else
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
    UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } state_t;
`endif

  localparam logic [IR_WIDTH-1:0] OP_EXTEST   = IR_WIDTH'(0);
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE   = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_INTEST   = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_RUNBIST  = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] OP_CLAMP    = IR_WIDTH'(4);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(5);
  localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(6);
  localparam logic [IR_WIDTH-1:0] OP_HIGHZ    = IR_WIDTH'(7);

  state_t              state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir;
  logic                bypass;
  logic                dr_tdo;

  // Rising edge: state transitions, IR shift stage and bypass bit
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state  <= TLR;
      ir_sr  <= '0;
      bypass <= 1'b0;
    end else begin
      case (state)
        CAP_IR:  ir_sr  <= IR_CAPTURE;
        SH_IR:   ir_sr  <= {TDI, ir_sr[IR_WIDTH-1:1]};
        CAP_DR:  bypass <= 1'b0;
        SH_DR:   bypass <= TDI;
        default: ;
      endcase
      case (state)
        TLR:     state <= TMS ? TLR    : RTI;
        RTI:     state <= TMS ? SEL_DR : RTI;
        SEL_DR:  state <= TMS ? SEL_IR : CAP_DR;
        CAP_DR:  state <= TMS ? EX1_DR : SH_DR;
        SH_DR:   state <= TMS ? EX1_DR : SH_DR;
        EX1_DR:  state <= TMS ? UPD_DR : PAU_DR;
        PAU_DR:  state <= TMS ? EX2_DR : PAU_DR;
        EX2_DR:  state <= TMS ? UPD_DR : SH_DR;
        UPD_DR:  state <= TMS ? SEL_DR : RTI;
        SEL_IR:  state <= TMS ? TLR    : CAP_IR;
        CAP_IR:  state <= TMS ? EX1_IR : SH_IR;
        SH_IR:   state <= TMS ? EX1_IR : SH_IR;
        EX1_IR:  state <= TMS ? UPD_IR : PAU_IR;
        PAU_IR:  state <= TMS ? EX2_IR : PAU_IR;
        EX2_IR:  state <= TMS ? UPD_IR : SH_IR;
        UPD_IR:  state <= TMS ? SEL_DR : RTI;
        default: state <= TLR;
      endcase
    end
  end

  assign CAPTUREDR = (state == CAP_DR);
  assign SHIFTDR   = (state == SH_DR);
  assign UPDATEDR  = (state == UPD_DR);
  assign ENABLE    = (state inside {CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR});

`ifdef TAP_STATE_PORT_EN
  assign TAP_STATE = state;
`endif

  always_comb begin
    BYPASS_SELECT   = 1'b0;
    SAMPLE_SELECT   = 1'b0;
    EXTEST_SELECT   = 1'b0;
    INTEST_SELECT   = 1'b0;
    RUNBIST_SELECT  = 1'b0;
    CLAMP_SELECT    = 1'b0;
    IDCODE_SELECT   = 1'b0;
    USERCODE_SELECT = 1'b0;
    HIGHZ_SELECT    = 1'b0;
    case (ir)
      OP_EXTEST:   EXTEST_SELECT   = 1'b1;
      OP_SAMPLE:   SAMPLE_SELECT   = 1'b1;
      OP_INTEST:   INTEST_SELECT   = 1'b1;
      OP_RUNBIST:  RUNBIST_SELECT  = 1'b1;
      OP_CLAMP:    CLAMP_SELECT    = 1'b1;
      OP_IDCODE:   IDCODE_SELECT   = 1'b1;
      OP_USERCODE: USERCODE_SELECT = 1'b1;
      OP_HIGHZ:    HIGHZ_SELECT    = 1'b1;
      default:     BYPASS_SELECT   = 1'b1;
    endcase
  end

  // CLAMP and HIGHZ fall through to the bypass bit along with undefined codes
  always_comb begin
    if (IDCODE_SELECT)
      dr_tdo = ID_REG_TDO;
    else if (USERCODE_SELECT)
      dr_tdo = USER_REG_TDO;
    else if (EXTEST_SELECT || SAMPLE_SELECT || INTEST_SELECT || RUNBIST_SELECT)
      dr_tdo = BSR_TDO;
    else
      dr_tdo = bypass;
  end

  // Falling edge: instruction update, TDO and its pad enable
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      ir     <= IR_RESET;
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      if (state == TLR)
        ir <= IR_RESET;
      else if (state == UPD_IR)
        ir <= ir_sr;
      if (state == SH_IR)
        TDO <= ir_sr[0];
      else if (state == SH_DR)
        TDO <= dr_tdo;
      TDO_EN <= (state == SH_IR) || (state == SH_DR);
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed vector table, hand-written corner sequences,
// then random TMS/TDI traffic compared against a table-based TAP model.
module tb_jtag_tap_ctrl;
  logic TCK, TRST, TMS, TDI;
  logic TDO, TDO_EN, ENABLE, CAPTUREDR, SHIFTDR, UPDATEDR;
  logic BSR_TDO, ID_REG_TDO, USER_REG_TDO;
  logic BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT;
  logic CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT;

  jtag_tap_ctrl dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .ENABLE(ENABLE), .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
    .BSR_TDO(BSR_TDO), .ID_REG_TDO(ID_REG_TDO), .USER_REG_TDO(USER_REG_TDO),
    .BYPASS_SELECT(BYPASS_SELECT), .SAMPLE_SELECT(SAMPLE_SELECT),
    .EXTEST_SELECT(EXTEST_SELECT), .INTEST_SELECT(INTEST_SELECT),
    .RUNBIST_SELECT(RUNBIST_SELECT), .CLAMP_SELECT(CLAMP_SELECT),
    .IDCODE_SELECT(IDCODE_SELECT), .USERCODE_SELECT(USERCODE_SELECT),
    .HIGHZ_SELECT(HIGHZ_SELECT)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Select bit order: BYPASS SAMPLE EXTEST INTEST RUNBIST CLAMP IDCODE USERCODE HIGHZ
  localparam logic [8:0] S_ID = 9'b000000100;
  localparam logic [8:0] S_BY = 9'b100000000;
  localparam logic [8:0] S_US = 9'b000000010;
  localparam logic [8:0] S_EX = 9'b001000000;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        tms;
    logic        tdi;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [8:0] sel_now();
    return {BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT,
            CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT};
  endfunction

  function automatic logic [14:0] obs();
    return {TDO, TDO_EN, ENABLE, CAPTUREDR, SHIFTDR, UPDATEDR, sel_now()};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #2;
  endtask

  task automatic add_row(input logic tms, input logic tdi, input logic tdo, input logic en,
                         input logic [3:0] strb, input logic [8:0] sel);
    vec_t v;
    v.tms = tms; v.tdi = tdi; v.exp = {tdo, en, strb, sel};
    tbl.push_back(v);
  endtask

  task automatic load_ir(input logic [3:0] code);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) tick(i == 3, code[i]);
    tick(1, 0); tick(0, 0);
  endtask

  // Reference model: states numbered in 1149.1 table order, transitions by lookup
  // 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR 7 Ex2DR 8 UpdDR
  // 9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauIR 14 Ex2IR 15 UpdIR
  int ns0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int ns1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int         m_st;
  logic [3:0] m_ir, m_sr;
  logic       m_byp, m_tdo, m_en;

  function automatic logic [8:0] model_sel(input logic [3:0] code);
    case (code)
      4'h0: return 9'b001000000;
      4'h1: return 9'b010000000;
      4'h2: return 9'b000100000;
      4'h3: return 9'b000010000;
      4'h4: return 9'b000001000;
      4'h5: return 9'b000000100;
      4'h6: return 9'b000000010;
      4'h7: return 9'b000000001;
      default: return 9'b100000000;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_ir = 4'b0101; m_sr = 4'b0000; m_byp = 1'b0; m_tdo = 1'b0; m_en = 1'b0;
  endtask

  task automatic model_step(input logic tms, input logic tdi, input logic bsr,
                            input logic id, input logic usr);
    if (m_st == 10) m_sr = 4'b0101;
    else if (m_st == 11) m_sr = {tdi, m_sr[3:1]};
    if (m_st == 3) m_byp = 1'b0;
    else if (m_st == 4) m_byp = tdi;
    m_st = tms ? ns1[m_st] : ns0[m_st];
    if (m_st == 0) m_ir = 4'b0101;
    else if (m_st == 15) m_ir = m_sr;
    if (m_st == 11) m_tdo = m_sr[0];
    else if (m_st == 4) begin
      if (m_ir == 4'h5) m_tdo = id;
      else if (m_ir == 4'h6) m_tdo = usr;
      else if (m_ir <= 4'h3) m_tdo = bsr;
      else m_tdo = m_byp;
    end
    m_en = (m_st == 11) || (m_st == 4);
  endtask

  function automatic logic [14:0] model_obs();
    logic enable;
    enable = (m_st >= 3) && (m_st <= 8);
    return {m_tdo, m_en, enable, m_st == 3, m_st == 4, m_st == 8, model_sel(m_ir)};
  endfunction

  initial begin
    int mism, ncap, nsh, nupd, nena, nten;
    logic r;
    logic [8:0] tmsv;

    TRST = 1'b1; TMS = 1'b0; TDI = 1'b0;
    BSR_TDO = 1'b0; ID_REG_TDO = 1'b0; USER_REG_TDO = 1'b0;
    #11;
    chk("reset_state", 32'(obs()), 32'({2'b00, 4'b0000, S_ID}));
    #1 TRST = 1'b0;

    // IR scan capturing 0101 with TDI all ones, then a bypass DR scan of 1,0,1,1
    add_row(0, 0, 0, 0, 4'b0000, S_ID);
    add_row(1, 0, 0, 0, 4'b0000, S_ID);
    add_row(1, 0, 0, 0, 4'b0000, S_ID);
    add_row(0, 0, 0, 0, 4'b0000, S_ID);
    add_row(0, 0, 1, 1, 4'b0000, S_ID);
    add_row(0, 1, 0, 1, 4'b0000, S_ID);
    add_row(0, 1, 1, 1, 4'b0000, S_ID);
    add_row(0, 1, 0, 1, 4'b0000, S_ID);
    add_row(1, 1, 0, 0, 4'b0000, S_ID);
    add_row(1, 0, 0, 0, 4'b0000, S_BY);
    add_row(0, 0, 0, 0, 4'b0000, S_BY);
    add_row(1, 0, 0, 0, 4'b0000, S_BY);
    add_row(0, 0, 0, 0, 4'b1100, S_BY);
    add_row(0, 0, 0, 1, 4'b1010, S_BY);
    add_row(0, 1, 1, 1, 4'b1010, S_BY);
    add_row(0, 0, 0, 1, 4'b1010, S_BY);
    add_row(0, 1, 1, 1, 4'b1010, S_BY);
    add_row(1, 1, 1, 0, 4'b1000, S_BY);
    add_row(1, 0, 1, 0, 4'b1001, S_BY);
    add_row(0, 0, 1, 0, 4'b0000, S_BY);
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].tms, tbl[i].tdi);
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end

    load_ir(4'h9);
    chk("ir9_bypass", 32'(sel_now()), 32'(S_BY));
    load_ir(4'h6);
    chk("ir6_usercode", 32'(sel_now()), 32'(S_US));
    tick(1, 0); tick(0, 0);
    mism = 0;
    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom_range(1));
      USER_REG_TDO = r; ID_REG_TDO = ~r; BSR_TDO = ~r;
      tick(0, 0);
      if (TDO !== r || SHIFTDR !== 1'b1) mism++;
    end
    chk("usercode_tdo", 32'(mism), 32'(0));
    tick(1, 0); tick(1, 0); tick(0, 0);

    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tms5_tlr", 32'(obs() & 15'h0FFF), 32'({4'b0000, S_ID}));
    tick(0, 0);

    load_ir(4'h0);
    chk("extest_sel", 32'(sel_now()), 32'(S_EX));
    tick(1, 0);
    tmsv = 9'b000000000;
    ncap = 0; nsh = 0; nupd = 0; nena = 0; nten = 0; mism = 0;
    for (int i = 0; i < 12; i++) begin
      r = 1'($urandom_range(1));
      BSR_TDO = r; ID_REG_TDO = ~r; USER_REG_TDO = ~r;
      tick((i == 9) || (i == 10), 1'($urandom_range(1)));
      ncap += int'(CAPTUREDR); nsh += int'(SHIFTDR); nupd += int'(UPDATEDR);
      nena += int'(ENABLE); nten += int'(TDO_EN);
      if (TDO_EN !== SHIFTDR) mism++;
      if (SHIFTDR && TDO !== r) mism++;
    end
    chk("extest_capturedr_cycles", 32'(ncap), 32'(1));
    chk("extest_shiftdr_cycles", 32'(nsh), 32'(8));
    chk("extest_updatedr_cycles", 32'(nupd), 32'(1));
    chk("extest_enable_cycles", 32'(nena), 32'(11));
    chk("extest_tdo_en_cycles", 32'(nten), 32'(8));
    chk("extest_tdo_bsr", 32'(mism), 32'(0));
    if (tmsv != 9'b0) mism++;

    load_ir(4'hF);
    tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1);
    chk("pre_reset_tdo", 32'({TDO, TDO_EN, SHIFTDR}), 32'(3'b111));
    TRST = 1'b1;
    #1;
    chk("reset_mid_shdr", 32'(obs()), 32'({2'b00, 4'b0000, S_ID}));
    TRST = 1'b0;
    tick(0, 0);
    chk("after_reset_shdr", 32'(obs()), 32'({2'b00, 4'b0000, S_ID}));

    load_ir(4'h6);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1); tick(0, 1);
    TRST = 1'b1;
    #1;
    TRST = 1'b0;
    tick(1, 0); tick(0, 0);
    chk("reset_mid_shir", 32'(obs()), 32'({2'b00, 4'b0000, S_ID}));

    TRST = 1'b1;
    model_reset();
    #1;
    TRST = 1'b0;
    mism = 0;
    for (int i = 0; i < 2000; i++) begin
      logic tms_r, tdi_r, bsr_r, id_r, usr_r;
      tms_r = ($urandom_range(99) < 30);
      tdi_r = 1'($urandom_range(1));
      bsr_r = 1'($urandom_range(1));
      id_r  = 1'($urandom_range(1));
      usr_r = 1'($urandom_range(1));
      BSR_TDO = bsr_r; ID_REG_TDO = id_r; USER_REG_TDO = usr_r;
      model_step(tms_r, tdi_r, bsr_r, id_r, usr_r);
      tick(tms_r, tdi_r);
      if (obs() !== model_obs()) begin
        mism++;
        if (mism <= 5) chk($sformatf("random_cycle%0d", i), 32'(obs()), 32'(model_obs()));
      end else begin
        chk($sformatf("random_cycle%0d", i), 32'(obs()), 32'(model_obs()));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
